// File: rtl/rs_issue_select_if.sv
// Dispatch, CDB snoop and issue handshake bundle for one reservation-station bank.
interface rs_issue_select_if #(
  parameter int DEPTH = 4,
  parameter int OPW   = 4,
  parameter int TAGW  = 5,
  parameter int XLEN  = 32
);
  localparam int IW = $clog2(DEPTH);

  logic            disp_valid;
  logic            disp_ready;
  logic [OPW-1:0]  disp_op;
  logic [TAGW-1:0] disp_dest;
  logic [TAGW-1:0] disp_q1;
  logic [XLEN-1:0] disp_v1;
  logic            disp_rdy1;
  logic [TAGW-1:0] disp_q2;
  logic [XLEN-1:0] disp_v2;
  logic            disp_rdy2;

  logic            cdb_valid;
  logic [TAGW-1:0] cdb_tag;
  logic [XLEN-1:0] cdb_data;

  logic            iss_valid;
  logic            iss_ready;
  logic [OPW-1:0]  iss_op;
  logic [TAGW-1:0] iss_dest;
  logic [XLEN-1:0] iss_src1;
  logic [XLEN-1:0] iss_src2;

  logic [IW:0]     occupancy;

  modport master (
    output disp_valid, disp_op, disp_dest, disp_q1, disp_v1, disp_rdy1,
           disp_q2, disp_v2, disp_rdy2, cdb_valid, cdb_tag, cdb_data, iss_ready,
    input  disp_ready, iss_valid, iss_op, iss_dest, iss_src1, iss_src2, occupancy
  );

  modport slave (
    input  disp_valid, disp_op, disp_dest, disp_q1, disp_v1, disp_rdy1,
           disp_q2, disp_v2, disp_rdy2, cdb_valid, cdb_tag, cdb_data, iss_ready,
    output disp_ready, iss_valid, iss_op, iss_dest, iss_src1, iss_src2, occupancy
  );
endinterface

// File: rtl/rs_issue_select.sv
// Reservation-station bank: dispatch into free entries, CDB operand wakeup,
// lowest-index ready select with a stable hold under functional-unit backpressure.
//
// state  | meaning
// SELECT | present the lowest-index eligible entry (if any)
// HOLD   | FU stalled; keep presenting entry hold_idx until accepted
module rs_issue_select #(
  parameter int DEPTH = 4,
  parameter int OPW   = 4,
  parameter int TAGW  = 5,
  parameter int XLEN  = 32
) (
  input logic              clk,
  input logic              reset,
  input logic              flush,
  rs_issue_select_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [0:0] SELECT = 1'b0;
  localparam logic [0:0] HOLD   = 1'b1;

  logic [0:0]       state;
  logic [IW-1:0]    hold_idx;
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] rdy1;
  logic [DEPTH-1:0] rdy2;
  logic [OPW-1:0]   op_q   [DEPTH];
  logic [TAGW-1:0]  dest_q [DEPTH];
  logic [TAGW-1:0]  q1     [DEPTH];
  logic [TAGW-1:0]  q2     [DEPTH];
  logic [XLEN-1:0]  v1     [DEPTH];
  logic [XLEN-1:0]  v2     [DEPTH];

  logic [DEPTH-1:0] elig;
  logic [IW-1:0]    sel;
  logic [IW-1:0]    alloc_idx;
  logic [IW-1:0]    cur_idx;
  logic [IW:0]      occ;
  logic             any_elig;
  logic             iss_valid_w;
  logic             iss_fire;
  logic             disp_fire;
  logic             full;
  logic [DEPTH-1:0] clr_mask;
  logic [DEPTH-1:0] set_mask;
  logic             d_rdy1;
  logic             d_rdy2;
  logic [XLEN-1:0]  d_v1;
  logic [XLEN-1:0]  d_v2;

  assign elig = busy & rdy1 & rdy2;

  // Descending scan so the last hit is the lowest index.
  always_comb begin
    sel       = '0;
    any_elig  = 1'b0;
    alloc_idx = '0;
    occ       = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        sel      = IW'(i);
        any_elig = 1'b1;
      end
      if (!busy[i]) alloc_idx = IW'(i);
      occ = occ + (IW+1)'(busy[i]);
    end
  end

  assign full        = &busy;
  assign cur_idx     = (state == HOLD) ? hold_idx : sel;
  assign iss_valid_w = (state == HOLD) | any_elig;
  assign iss_fire    = iss_valid_w & bus.iss_ready;
  assign disp_fire   = bus.disp_valid & ~full;
  assign clr_mask    = iss_fire  ? (DEPTH'(1) << cur_idx)   : '0;
  assign set_mask    = disp_fire ? (DEPTH'(1) << alloc_idx) : '0;

  // A dispatch can catch the broadcast of its own producer in the same cycle.
  assign d_rdy1 = bus.disp_rdy1 | (bus.cdb_valid & (bus.disp_q1 == bus.cdb_tag));
  assign d_rdy2 = bus.disp_rdy2 | (bus.cdb_valid & (bus.disp_q2 == bus.cdb_tag));
  assign d_v1   = bus.disp_rdy1 ? bus.disp_v1 : bus.cdb_data;
  assign d_v2   = bus.disp_rdy2 ? bus.disp_v2 : bus.cdb_data;

  assign bus.disp_ready = ~full;
  assign bus.occupancy  = occ;
  assign bus.iss_valid  = iss_valid_w;
  assign bus.iss_op     = iss_valid_w ? op_q[cur_idx]   : '0;
  assign bus.iss_dest   = iss_valid_w ? dest_q[cur_idx] : '0;
  assign bus.iss_src1   = iss_valid_w ? v1[cur_idx]     : '0;
  assign bus.iss_src2   = iss_valid_w ? v2[cur_idx]     : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy     <= '0;
      state    <= SELECT;
      hold_idx <= '0;
    end else if (flush) begin
      busy  <= '0;
      state <= SELECT;
    end else begin
      busy <= (busy & ~clr_mask) | set_mask;
      case (state)
        SELECT: if (iss_valid_w && !bus.iss_ready) begin
          state    <= HOLD;
          hold_idx <= sel;
        end
        HOLD:    if (bus.iss_ready) state <= SELECT;
        default: state <= SELECT;
      endcase
    end
  end

  // Payload and readiness need no reset: busy gates every use of them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (set_mask[i]) begin
        op_q[i]   <= bus.disp_op;
        dest_q[i] <= bus.disp_dest;
        q1[i]     <= bus.disp_q1;
        q2[i]     <= bus.disp_q2;
        rdy1[i]   <= d_rdy1;
        rdy2[i]   <= d_rdy2;
        v1[i]     <= d_v1;
        v2[i]     <= d_v2;
      end else if (busy[i] && bus.cdb_valid) begin
        if (!rdy1[i] && q1[i] == bus.cdb_tag) begin
          rdy1[i] <= 1'b1;
          v1[i]   <= bus.cdb_data;
        end
        if (!rdy2[i] && q2[i] == bus.cdb_tag) begin
          rdy2[i] <= 1'b1;
          v2[i]   <= bus.cdb_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_rs_issue_select.sv
// Self-checking bench for rs_issue_select: directed scenarios plus random traffic vs an array model.
module tb_rs_issue_select;
  localparam int DEPTH = 4;
  localparam int OPW   = 4;
  localparam int TAGW  = 5;
  localparam int XLEN  = 32;
  localparam int IW    = $clog2(DEPTH);
  localparam int OW    = 1 + OPW + TAGW + 2 * XLEN + IW + 1 + 1;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rs_issue_select_if #(.DEPTH(DEPTH), .OPW(OPW), .TAGW(TAGW), .XLEN(XLEN)) bus();

  rs_issue_select #(.DEPTH(DEPTH), .OPW(OPW), .TAGW(TAGW), .XLEN(XLEN)) dut (
    .clk  (clk),
    .reset(reset),
    .flush(flush),
    .bus  (bus)
  );

  wire [OW-1:0] dut_out = {bus.iss_valid, bus.iss_op, bus.iss_dest, bus.iss_src1,
                           bus.iss_src2, bus.occupancy, bus.disp_ready};

  // Reference model: one record per slot, plus the slot currently held under a stall.
  bit              m_busy [DEPTH];
  logic [OPW-1:0]  m_op   [DEPTH];
  logic [TAGW-1:0] m_dest [DEPTH];
  logic [TAGW-1:0] m_q1   [DEPTH];
  logic [TAGW-1:0] m_q2   [DEPTH];
  logic [XLEN-1:0] m_v1   [DEPTH];
  logic [XLEN-1:0] m_v2   [DEPTH];
  bit              m_r1   [DEPTH];
  bit              m_r2   [DEPTH];
  bit              m_hold;
  int              m_hold_idx;

  function automatic int m_pick();
    if (m_hold) return m_hold_idx;
    for (int i = 0; i < DEPTH; i++)
      if (m_busy[i] && m_r1[i] && m_r2[i]) return i;
    return -1;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  function automatic logic [OW-1:0] model_out();
    int k = m_pick();
    int n = m_count();
    logic rdy = (n < DEPTH);
    if (k >= 0)
      return {1'b1, m_op[k], m_dest[k], m_v1[k], m_v2[k], (IW+1)'(n), rdy};
    return {1'b0, OPW'(0), TAGW'(0), XLEN'(0), XLEN'(0), (IW+1)'(n), rdy};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
    m_hold = 0;
    m_hold_idx = 0;
  endtask

  task automatic model_edge();
    int k;
    int alloc;
    if (flush) begin
      model_reset();
      return;
    end
    k = m_pick();
    alloc = -1;
    for (int i = DEPTH - 1; i >= 0; i--) if (!m_busy[i]) alloc = i;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_busy[i] && bus.cdb_valid) begin
        if (!m_r1[i] && m_q1[i] == bus.cdb_tag) begin m_r1[i] = 1; m_v1[i] = bus.cdb_data; end
        if (!m_r2[i] && m_q2[i] == bus.cdb_tag) begin m_r2[i] = 1; m_v2[i] = bus.cdb_data; end
      end
    end
    if (k >= 0) begin
      if (bus.iss_ready) begin
        m_busy[k] = 0;
        m_hold = 0;
      end else begin
        m_hold = 1;
        m_hold_idx = k;
      end
    end
    if (bus.disp_valid && alloc >= 0) begin
      m_busy[alloc] = 1;
      m_op[alloc]   = bus.disp_op;
      m_dest[alloc] = bus.disp_dest;
      m_q1[alloc]   = bus.disp_q1;
      m_q2[alloc]   = bus.disp_q2;
      m_r1[alloc]   = bus.disp_rdy1 || (bus.cdb_valid && bus.disp_q1 == bus.cdb_tag);
      m_r2[alloc]   = bus.disp_rdy2 || (bus.cdb_valid && bus.disp_q2 == bus.cdb_tag);
      m_v1[alloc]   = bus.disp_rdy1 ? bus.disp_v1 : bus.cdb_data;
      m_v2[alloc]   = bus.disp_rdy2 ? bus.disp_v2 : bus.cdb_data;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.disp_valid = 1'b0;
    bus.cdb_valid  = 1'b0;
    bus.iss_ready  = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic set_disp(input logic [OPW-1:0] op, input logic [TAGW-1:0] dest,
                          input logic [TAGW-1:0] q1, input logic [XLEN-1:0] v1, input logic r1,
                          input logic [TAGW-1:0] q2, input logic [XLEN-1:0] v2, input logic r2);
    bus.disp_valid = 1'b1;
    bus.disp_op    = op;
    bus.disp_dest  = dest;
    bus.disp_q1    = q1;
    bus.disp_v1    = v1;
    bus.disp_rdy1  = r1;
    bus.disp_q2    = q2;
    bus.disp_v2    = v2;
    bus.disp_rdy2  = r2;
  endtask

  task automatic set_cdb(input logic [TAGW-1:0] tag, input logic [XLEN-1:0] data);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = tag;
    bus.cdb_data  = data;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    set_disp(0, 0, 0, 0, 0, 0, 0, 0);
    bus.disp_valid = 1'b0;
    set_cdb(0, 0);
    bus.cdb_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++; if (bus.iss_valid !== 1'b0) begin failures++; $display("FAIL reset_iss_valid got=%b exp=0", bus.iss_valid); end
    checks++; if (bus.disp_ready !== 1'b1) begin failures++; $display("FAIL reset_disp_ready got=%b exp=1", bus.disp_ready); end
    checks++; if (bus.occupancy !== '0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", bus.occupancy); end
    reset = 1'b1;
    repeat (3) begin
      tick();
      checks++; if (dut_out !== model_out()) begin failures++; $display("FAIL reset_idle got=%h exp=%h", dut_out, model_out()); end
    end
  endtask

  task automatic test_ready_dispatch();
    set_disp(3, 7, 0, 32'h10, 1, 0, 32'h20, 1);
    tick();
    idle_inputs();
    checks++; if ({bus.iss_valid, bus.iss_op, bus.iss_dest, bus.iss_src1, bus.iss_src2} !== {1'b1, 4'd3, 5'd7, 32'h10, 32'h20}) begin
      failures++; $display("FAIL ready_issue got=%b/%0d/%0d/%h/%h exp=1/3/7/10/20", bus.iss_valid, bus.iss_op, bus.iss_dest, bus.iss_src1, bus.iss_src2);
    end
    bus.iss_ready = 1'b1;
    tick();
    bus.iss_ready = 1'b0;
    checks++; if (bus.occupancy !== '0 || bus.iss_valid !== 1'b0) begin failures++; $display("FAIL ready_free got=%0d/%b exp=0/0", bus.occupancy, bus.iss_valid); end
    checks++; if (dut_out !== model_out()) begin failures++; $display("FAIL ready_model got=%h exp=%h", dut_out, model_out()); end
  endtask

  task automatic test_wakeup_bypass();
    set_disp(1, 9, 5, 0, 0, 0, 32'h22, 1);
    tick();
    idle_inputs();
    tick();
    checks++; if (bus.iss_valid !== 1'b0) begin failures++; $display("FAIL wake_early got=%b exp=0", bus.iss_valid); end
    set_cdb(5, 32'hABCD);
    tick();
    idle_inputs();
    checks++; if ({bus.iss_valid, bus.iss_dest, bus.iss_src1, bus.iss_src2} !== {1'b1, 5'd9, 32'hABCD, 32'h22}) begin
      failures++; $display("FAIL wake_issue got=%b/%0d/%h/%h exp=1/9/abcd/22", bus.iss_valid, bus.iss_dest, bus.iss_src1, bus.iss_src2);
    end
    bus.iss_ready = 1'b1;
    tick();
    idle_inputs();
    set_disp(2, 10, 5, 0, 0, 0, 32'h33, 1);
    set_cdb(5, 32'hABCD);
    tick();
    idle_inputs();
    checks++; if ({bus.iss_valid, bus.iss_dest, bus.iss_src1, bus.iss_src2} !== {1'b1, 5'd10, 32'hABCD, 32'h33}) begin
      failures++; $display("FAIL bypass_issue got=%b/%0d/%h/%h exp=1/10/abcd/33", bus.iss_valid, bus.iss_dest, bus.iss_src1, bus.iss_src2);
    end
    bus.iss_ready = 1'b1;
    tick();
    idle_inputs();
    checks++; if (dut_out !== model_out()) begin failures++; $display("FAIL bypass_model got=%h exp=%h", dut_out, model_out()); end
  endtask

  task automatic test_full();
    logic [TAGW-1:0] drain_tag [3] = '{5'd10, 5'd12, 5'd13};
    for (int i = 0; i < DEPTH; i++) begin
      set_disp(OPW'(i), TAGW'(16 + i), TAGW'(10 + i), 0, 0, 0, XLEN'(i), 1);
      tick();
    end
    idle_inputs();
    checks++; if (bus.disp_ready !== 1'b0 || bus.occupancy !== (IW+1)'(DEPTH)) begin
      failures++; $display("FAIL full_state got=%b/%0d exp=0/%0d", bus.disp_ready, bus.occupancy, DEPTH);
    end
    set_disp(9, 31, 0, 32'h1, 1, 0, 32'h2, 1);
    tick();
    idle_inputs();
    checks++; if (bus.occupancy !== (IW+1)'(DEPTH) || bus.iss_valid !== 1'b0) begin
      failures++; $display("FAIL full_drop got=%0d/%b exp=%0d/0", bus.occupancy, bus.iss_valid, DEPTH);
    end
    set_cdb(11, 32'h55);
    tick();
    idle_inputs();
    checks++; if ({bus.iss_valid, bus.iss_dest, bus.iss_src1} !== {1'b1, 5'd17, 32'h55}) begin
      failures++; $display("FAIL full_wake got=%b/%0d/%h exp=1/17/55", bus.iss_valid, bus.iss_dest, bus.iss_src1);
    end
    bus.iss_ready = 1'b1;
    set_disp(8, 30, 0, 32'h7, 1, 0, 32'h8, 1);
    tick();
    idle_inputs();
    checks++; if (bus.occupancy !== (IW+1)'(DEPTH - 1) || bus.disp_ready !== 1'b1) begin
      failures++; $display("FAIL full_free got=%0d/%b exp=%0d/1", bus.occupancy, bus.disp_ready, DEPTH - 1);
    end
    for (int k = 0; k < 5; k++) begin
      bus.iss_ready = 1'b1;
      bus.cdb_valid = 1'b0;
      if (k < 3) set_cdb(drain_tag[k], XLEN'(32'h100 + k));
      tick();
      checks++; if (dut_out !== model_out()) begin failures++; $display("FAIL full_drain got=%h exp=%h", dut_out, model_out()); end
    end
    idle_inputs();
    checks++; if (bus.occupancy !== '0) begin failures++; $display("FAIL full_empty got=%0d exp=0", bus.occupancy); end
  endtask

  task automatic test_backpressure();
    set_disp(1, 1, 20, 0, 0, 0, 32'h11, 1);
    tick();
    set_disp(2, 2, 21, 0, 0, 0, 32'h22, 1);
    tick();
    set_disp(3, 3, 0, 32'h33, 1, 0, 32'h44, 1);
    tick();
    idle_inputs();
    checks++; if (bus.iss_valid !== 1'b1 || bus.iss_dest !== 5'd3) begin failures++; $display("FAIL bp_first got=%b/%0d exp=1/3", bus.iss_valid, bus.iss_dest); end
    tick();
    set_cdb(20, 32'h99);
    tick();
    idle_inputs();
    checks++; if (bus.iss_valid !== 1'b1 || bus.iss_dest !== 5'd3) begin failures++; $display("FAIL bp_hold got=%b/%0d exp=1/3", bus.iss_valid, bus.iss_dest); end
    tick();
    checks++; if (dut_out !== model_out()) begin failures++; $display("FAIL bp_hold_model got=%h exp=%h", dut_out, model_out()); end
    bus.iss_ready = 1'b1;
    tick();
    checks++; if ({bus.iss_valid, bus.iss_dest, bus.iss_src1} !== {1'b1, 5'd1, 32'h99}) begin
      failures++; $display("FAIL bp_next got=%b/%0d/%h exp=1/1/99", bus.iss_valid, bus.iss_dest, bus.iss_src1);
    end
    tick();
    checks++; if (bus.occupancy !== (IW+1)'(1)) begin failures++; $display("FAIL bp_occ got=%0d exp=1", bus.occupancy); end
    idle_inputs();
    set_cdb(21, 32'h77);
    tick();
    idle_inputs();
    tick();
    checks++; if (bus.iss_valid !== 1'b1 || bus.iss_dest !== 5'd2) begin failures++; $display("FAIL bp_hold2 got=%b/%0d exp=1/2", bus.iss_valid, bus.iss_dest); end
    #2 reset = 1'b0;
    #1;
    model_reset();
    checks++; if (bus.iss_valid !== 1'b0 || bus.occupancy !== '0 || bus.disp_ready !== 1'b1) begin
      failures++; $display("FAIL async_reset got=%b/%0d/%b exp=0/0/1", bus.iss_valid, bus.occupancy, bus.disp_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    checks++; if (dut_out !== model_out()) begin failures++; $display("FAIL post_reset got=%h exp=%h", dut_out, model_out()); end
  endtask

  task automatic test_flush();
    set_disp(4, 4, 0, 32'h4, 1, 0, 32'h4, 1);
    tick();
    set_disp(5, 5, 0, 32'h5, 1, 0, 32'h5, 1);
    tick();
    set_disp(6, 6, 25, 0, 0, 0, 32'h6, 1);
    tick();
    idle_inputs();
    checks++; if (bus.occupancy !== (IW+1)'(3) || bus.iss_valid !== 1'b1) begin
      failures++; $display("FAIL flush_pre got=%0d/%b exp=3/1", bus.occupancy, bus.iss_valid);
    end
    flush = 1'b1;
    bus.iss_ready = 1'b1;
    set_disp(7, 8, 0, 32'h8, 1, 0, 32'h8, 1);
    set_cdb(25, 32'h25);
    tick();
    idle_inputs();
    checks++; if (bus.occupancy !== '0 || bus.iss_valid !== 1'b0 || bus.disp_ready !== 1'b1) begin
      failures++; $display("FAIL flush_post got=%0d/%b/%b exp=0/0/1", bus.occupancy, bus.iss_valid, bus.disp_ready);
    end
    set_cdb(25, 32'h25);
    tick();
    idle_inputs();
    tick();
    checks++; if (bus.iss_valid !== 1'b0) begin failures++; $display("FAIL flush_stale got=%b exp=0", bus.iss_valid); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      idle_inputs();
      if ($urandom_range(0, 99) < 50)
        set_disp(OPW'($urandom), TAGW'($urandom), TAGW'($urandom_range(0, 7)), XLEN'($urandom),
                 1'($urandom_range(0, 1)), TAGW'($urandom_range(0, 7)), XLEN'($urandom),
                 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 99) < 50) set_cdb(TAGW'($urandom_range(0, 7)), XLEN'($urandom));
      bus.iss_ready = ($urandom_range(0, 99) < 55);
      flush = ($urandom_range(0, 99) < 3);
      tick();
      checks++; if (dut_out !== model_out()) begin failures++; $display("FAIL random_c%0d got=%h exp=%h", c, dut_out, model_out()); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_ready_dispatch();
    test_wakeup_bypass();
    test_full();
    test_backpressure();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
